// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve queue and its predictor hookup.
package branch_pkg;

  localparam int PC_W        = 16;
  // Slice of the PC the local direction predictor indexes with.
  localparam int PRED_IDX_HI = 8;
  localparam int PRED_IDX_LO = 2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/resolve/predictor-update bundle for branch_resolve_queue.
// Optional statistics ports exist only when BRANCH_RESOLVE_STATS_EN is defined.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_prediction;
  logic             full;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             upd_write_enabled;
  logic             upd_outcome;
  logic [PC_W-1:0]  upd_pc;
  logic             mispredict;
  logic [CNT_W-1:0] count;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispredicted;
`endif

`ifdef BRANCH_RESOLVE_STATS_EN
  modport slave (
    input  fetch_valid, fetch_pc, fetch_prediction, resolve_valid, resolve_taken, flush,
    output full, upd_write_enabled, upd_outcome, upd_pc, mispredict, count,
    output stat_resolved, stat_mispredicted
  );
  modport master (
    output fetch_valid, fetch_pc, fetch_prediction, resolve_valid, resolve_taken, flush,
    input  full, upd_write_enabled, upd_outcome, upd_pc, mispredict, count,
    input  stat_resolved, stat_mispredicted
  );
`else
  modport slave (
    input  fetch_valid, fetch_pc, fetch_prediction, resolve_valid, resolve_taken, flush,
    output full, upd_write_enabled, upd_outcome, upd_pc, mispredict, count
  );
  modport master (
    output fetch_valid, fetch_pc, fetch_prediction, resolve_valid, resolve_taken, flush,
    input  full, upd_write_enabled, upd_outcome, upd_pc, mispredict, count
  );
`endif

endinterface

// File: rtl/br_inflight_fifo.sv
// Circular buffer of in-flight branch entries with push/pop/clear and registered count/full.
// The head entry is readable combinationally so a branch pushed at one edge can resolve at the next.
module br_inflight_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              full_reg;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count_reg == '0);
  assign push_ok = push && !full_reg && !clear;
  assign pop_ok  = pop && !empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign head = mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
    // Clear discards everything still queued, including a same-cycle push.
    if (clear) begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CNT_W'(DEPTH));
    end
  end

  assign count = count_reg;
  assign full  = full_reg;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches; resolves against execute outcome, drives
// predictor updates and a mispredict pulse. BRANCH_RESOLVE_STATS_EN adds saturating counters.
import branch_pkg::*;

module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = branch_pkg::PC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_resolve_queue_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_W:0]    push_data;
  logic [PC_W:0]    head;
  logic [PC_W-1:0]  head_pc;
  logic             head_pred;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             wrong;
  logic             kill;

  logic             upd_write_enabled_reg;
  logic             upd_outcome_reg;
  logic [PC_W-1:0]  upd_pc_reg;
  logic             mispredict_reg;

  assign push_data = {bus.fetch_pc, bus.fetch_prediction};
  assign head_pc   = head[PC_W:1];
  assign head_pred = head[0];

  assign pop   = bus.resolve_valid && !empty;
  assign wrong = pop && (head_pred != bus.resolve_taken);
  // Anything fetched behind a mispredicted or flushed branch is wrong-path.
  assign kill  = bus.flush || wrong;
  assign push  = bus.fetch_valid && !full && !kill;

  br_inflight_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (PC_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (kill),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_write_enabled_reg <= 1'b0;
      upd_outcome_reg       <= 1'b0;
      upd_pc_reg            <= '0;
      mispredict_reg        <= 1'b0;
    end else begin
      upd_write_enabled_reg <= pop;
      mispredict_reg        <= wrong;
      if (pop) begin
        upd_outcome_reg <= bus.resolve_taken;
        upd_pc_reg      <= head_pc;
      end
    end
  end

  assign bus.full              = full;
  assign bus.count             = count;
  assign bus.upd_write_enabled = upd_write_enabled_reg;
  assign bus.upd_outcome       = upd_outcome_reg;
  assign bus.upd_pc            = upd_pc_reg;
  assign bus.mispredict        = mispredict_reg;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] stat_resolved_reg;
  logic [15:0] stat_mispredicted_reg;

  // Flush does not touch these; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_resolved_reg     <= '0;
      stat_mispredicted_reg <= '0;
    end else begin
      if (pop && (stat_resolved_reg != 16'hFFFF)) begin
        stat_resolved_reg <= stat_resolved_reg + 16'd1;
      end
      if (wrong && (stat_mispredicted_reg != 16'hFFFF)) begin
        stat_mispredicted_reg <= stat_mispredicted_reg + 16'd1;
      end
    end
  end

  assign bus.stat_resolved     = stat_resolved_reg;
  assign bus.stat_mispredicted = stat_mispredicted_reg;
`endif

endmodule
